hw_stack16: RTL and testbench
=============================

// Module: hw_stack16
// PURPOSE
//   Parameterised LIFO operand stack for the stack machine datapath; holds data words pushed by the ALU/memory path.
//   Presents the current top-of-stack word, registered, to the ALU and store paths.
//   Single-cycle push, pop and replace operations with full/empty status and sticky overflow/underflow error flags.
//   Sits beside the 16-bit datapath registers; the control unit issues push/pop.
// PARAMETERS
//   WIDTH   16  data word width in bits
//   DEPTH   8   number of stack entries (power of two, >=2)
//   CNT_W   4   width of count output; must hold DEPTH (log2(DEPTH)+1)
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low; reset=0 clears all state immediately
//   push       in   1      push din this cycle
//   pop        in   1      pop top entry this cycle
//   din        in   WIDTH  word to push
//   clr_err    in   1      synchronous clear of overflow/underflow flags
//   dout       out  WIDTH  registered top-of-stack word; 0 when empty
//   count      out  CNT_W  number of valid entries, 0..DEPTH
//   empty      out  1      count==0
//   full       out  1      count==DEPTH
//   overflow   out  1      sticky: push attempted while full (no pop)
//   underflow  out  1      sticky: pop attempted while empty (no push)
// BEHAVIOUR
//   - Reset (reset=0, async): count=0, dout=0, empty=1, full=0, overflow=0, underflow=0; storage contents don't-care.
//   - Ops are sampled on the rising clk edge; results (dout, count, flags) are visible after that edge: 1-cycle latency.
//   - Storage: DEPTH-entry register array indexed by count; entry count-1 is the top of stack; dout is a separate register mirroring it.
//   - push only, not full: mem[count]<=din; count<=count+1; dout<=din.
//   - push only, full: no state change except overflow<=1; dout and count unchanged.
//   - pop only, count>=2: count<=count-1; dout<=mem[count-2].
//   - pop only, count==1: count<=0; dout<=0.
//   - pop only, empty: no state change except underflow<=1.
//   - push and pop, count>=1: replace; mem[count-1]<=din; dout<=din; count unchanged; no flags set, even when full.
//   - push and pop, empty: treated as plain push; count<=1, dout<=din; underflow not set.
//   - Neither asserted: hold all state.
//   - empty/full are decoded from the count register, so they are glitch-free and registered.
//   - overflow/underflow: set per the rules above; clear on clr_err=1 at the clock edge.
//     If clr_err coincides with a new error in the same cycle, set wins and the flag reads 1.
//   - Count is never allowed outside 0..DEPTH; there is no wrap-around of the pointer.
//   - Reset asserted mid-operation overrides everything. After reset is released, the first edge with reset=1 performs the op.
// TESTING
//   1 Reset: hold reset=0, drive push=1 din=16'hFFFF for 3 clk -> count=0, dout=0, empty=1, both flags 0.
//   2 Push 16'h0001..16'h0008 (DEPTH=8) -> after each edge dout=last din; count steps 1..8; full=1 after 8th.
//     Then pop 8x -> dout=0007,0006,..,0001,0000; empty=1 at end.
//   3 Overflow: at full push 16'hBEEF -> count=8, dout=0008, overflow=1.
//     Then clr_err=1 -> overflow=0; dout unchanged.
//   4 Underflow: when empty pop=1 -> underflow=1, count=0, dout=0.
//     Then push=1,pop=1 din=16'h1234 -> count=1, dout=1234, underflow stays 1.
//   5 Replace: push A5A5, 5A5A, then push=1,pop=1 din=16'hC3C3 -> count=2, dout=C3C3.
//     Then pop -> dout=A5A5.
//   6 Async reset mid-stream: count=5, drop reset between edges -> count=0, dout=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/hw_stack16.sv
// LIFO operand stack with a registered top-of-stack word, full/empty decode
// and sticky overflow/underflow flags. Push, pop and replace all complete in one cycle.
module hw_stack16 #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   input  logic             clr_err,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             mem_we;
   logic [AW-1:0]    mem_idx;
   logic [AW-1:0]    top_idx;
   logic [AW-1:0]    below_idx;
   logic             is_empty;
   logic             is_full;

   assign is_empty  = (cnt_q == '0);
   assign is_full   = (cnt_q == CNT_FULL);
   assign top_idx   = AW'(cnt_q - CNT_ONE);
   assign below_idx = AW'(cnt_q - CNT_TWO);

   // Clear is applied first so that a same-cycle error set overrides it.
   always_comb begin
      mem_we  = 1'b0;
      mem_idx = AW'(cnt_q);
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      ovf_d   = clr_err ? 1'b0 : ovf_q;
      unf_d   = clr_err ? 1'b0 : unf_q;
      case ({push, pop})
         2'b10: begin
            if (is_full) begin
               ovf_d = 1'b1;
            end else begin
               mem_we  = 1'b1;
               mem_idx = AW'(cnt_q);
               cnt_d   = cnt_q + CNT_ONE;
               dout_d  = din;
            end
         end
         2'b01: begin
            if (is_empty) begin
               unf_d = 1'b1;
            end else if (cnt_q == CNT_ONE) begin
               cnt_d  = '0;
               dout_d = '0;
            end else begin
               cnt_d  = cnt_q - CNT_ONE;
               dout_d = mem[below_idx];
            end
         end
         2'b11: begin
            // Replace the top entry; on an empty stack this degrades to a plain push.
            mem_we = 1'b1;
            dout_d = din;
            if (is_empty) begin
               mem_idx = AW'(cnt_q);
               cnt_d   = CNT_ONE;
            end else begin
               mem_idx = top_idx;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= '0;
         dout_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         dout_q <= dout_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   // Storage contents are don't-care after reset, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_idx] <= din;
      end
   end

   assign dout      = dout_q;
   assign count     = cnt_q;
   assign empty     = is_empty;
   assign full      = is_full;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule

// File: tb/tb_hw_stack16.sv
// Bench for hw_stack16: directed scenarios plus randomized push/pop/clear traffic
// compared against a queue-based LIFO model.
module tb_hw_stack16;

   localparam int WIDTH = 16;
   localparam int DEPTH = 8;
   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic             push;
   logic             pop;
   logic [WIDTH-1:0] din;
   logic             clr_err;
   logic [WIDTH-1:0] dout;
   logic [CNT_W-1:0] count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;

   int n_checks = 0;
   int n_errors = 0;

   logic [WIDTH-1:0] exp_q[$];
   logic             m_ovf;
   logic             m_unf;

   hw_stack16 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .din       (din),
      .clr_err   (clr_err),
      .dout      (dout),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .overflow  (overflow),
      .underflow (underflow)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // LIFO rules expressed directly on a queue.
   task automatic model_step(input logic p, input logic po, input logic [WIDTH-1:0] d, input logic c);
      logic ovf_set, unf_set;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      if (p && !po) begin
         if (exp_q.size() == DEPTH) ovf_set = 1'b1;
         else exp_q.push_back(d);
      end else if (po && !p) begin
         if (exp_q.size() == 0) unf_set = 1'b1;
         else void'(exp_q.pop_back());
      end else if (p && po) begin
         if (exp_q.size() == 0) exp_q.push_back(d);
         else exp_q[exp_q.size()-1] = d;
      end
      m_ovf = ovf_set ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_unf = unf_set ? 1'b1 : (c ? 1'b0 : m_unf);
   endtask

   task automatic check_all(input string tag);
      logic [WIDTH-1:0] e_dout;
      e_dout = (exp_q.size() == 0) ? '0 : exp_q[exp_q.size()-1];
      check({tag, ".dout"},      32'(dout),      32'(e_dout));
      check({tag, ".count"},     32'(count),     32'(exp_q.size()));
      check({tag, ".empty"},     32'(empty),     32'(exp_q.size() == 0));
      check({tag, ".full"},      32'(full),      32'(exp_q.size() == DEPTH));
      check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
      check({tag, ".underflow"}, 32'(underflow), 32'(m_unf));
   endtask

   // driver: called at a falling edge, applies one op across the next rising edge
   task automatic op(input string tag, input logic p, input logic po, input logic [WIDTH-1:0] d,
                     input logic c);
      push = p; pop = po; din = d; clr_err = c;
      @(posedge clk);
      model_step(p, po, d, c);
      @(negedge clk);
      check_all(tag);
      push = 1'b0; pop = 1'b0; clr_err = 1'b0;
   endtask

   initial begin
      int bias;
      reset = 1'b0; push = 1'b0; pop = 1'b0; din = '0; clr_err = 1'b0;
      model_reset();

      // reset held while pushing must leave the stack cleared
      @(negedge clk);
      push = 1'b1; din = 16'hFFFF;
      repeat (3) @(negedge clk);
      check_all("reset_hold");
      push = 1'b0;
      reset = 1'b1;

      // fill then drain
      for (int i = 1; i <= DEPTH; i++) begin
         op("fill", 1'b1, 1'b0, WIDTH'(i), 1'b0);
         check("fill_dout", 32'(dout), 32'(i));
      end
      check("fill_full", 32'(full), 32'd1);
      for (int i = DEPTH - 1; i >= 0; i--) begin
         op("drain", 1'b0, 1'b1, '0, 1'b0);
         check("drain_dout", 32'(dout), 32'(i));
      end
      check("drain_empty", 32'(empty), 32'd1);

      // overflow and clear
      for (int i = 1; i <= DEPTH; i++) op("refill", 1'b1, 1'b0, WIDTH'(i), 1'b0);
      op("ovf", 1'b1, 1'b0, 16'hBEEF, 1'b0);
      check("ovf_flag", 32'(overflow), 32'd1);
      check("ovf_dout", 32'(dout), 32'h0008);
      check("ovf_count", 32'(count), 32'd8);
      op("ovf_clr", 1'b0, 1'b0, '0, 1'b1);
      check("ovf_clr_flag", 32'(overflow), 32'd0);
      check("ovf_clr_dout", 32'(dout), 32'h0008);
      // replace while full sets no flag
      op("repl_full", 1'b1, 1'b1, 16'h7777, 1'b0);
      check("repl_full_ovf", 32'(overflow), 32'd0);
      // same-cycle set and clear: set wins
      op("ovf_setclr", 1'b1, 1'b0, 16'h1111, 1'b1);
      check("ovf_setclr_flag", 32'(overflow), 32'd1);
      op("ovf_clr2", 1'b0, 1'b0, '0, 1'b1);

      // underflow, then push+pop on empty behaves as push
      while (exp_q.size() != 0) op("drain2", 1'b0, 1'b1, '0, 1'b0);
      op("unf", 1'b0, 1'b1, '0, 1'b0);
      check("unf_flag", 32'(underflow), 32'd1);
      check("unf_dout", 32'(dout), 32'd0);
      op("pp_empty", 1'b1, 1'b1, 16'h1234, 1'b0);
      check("pp_empty_count", 32'(count), 32'd1);
      check("pp_empty_dout", 32'(dout), 32'h1234);
      check("pp_empty_unf", 32'(underflow), 32'd1);
      op("unf_clr", 1'b0, 1'b1, '0, 1'b1);

      // replace
      op("r_a", 1'b1, 1'b0, 16'hA5A5, 1'b0);
      op("r_b", 1'b1, 1'b0, 16'h5A5A, 1'b0);
      op("r_rep", 1'b1, 1'b1, 16'hC3C3, 1'b0);
      check("repl_count", 32'(count), 32'd2);
      check("repl_dout", 32'(dout), 32'hC3C3);
      op("r_pop", 1'b0, 1'b1, '0, 1'b0);
      check("repl_pop_dout", 32'(dout), 32'hA5A5);

      // async reset mid-stream, observed before the next clock edge
      while (exp_q.size() < 5) op("pre_rst", 1'b1, 1'b0, WIDTH'($urandom), 1'b0);
      check("pre_rst_count", 32'(count), 32'd5);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check("async_count", 32'(count), 32'd0);
      check("async_dout", 32'(dout), 32'd0);
      check("async_empty", 32'(empty), 32'd1);
      @(negedge clk);
      reset = 1'b1;

      // randomized traffic, alternating push-heavy and pop-heavy phases
      bias = 70;
      for (int n = 0; n < 600; n++) begin
         int r;
         logic p, po, c;
         if (n % 40 == 0) bias = 100 - bias;
         r  = $urandom_range(0, 99);
         p  = (r < bias);
         po = ($urandom_range(0, 99) < (100 - bias));
         c  = ($urandom_range(0, 7) == 0);
         op("rand", p, po, WIDTH'($urandom), c);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
